// File: rtl/issue_pkg.sv
// Purpose: shared sizing, FU index constants and helpers for the issue scheduler.
// Contents: RS_ENTRIES/NUM_FU/IDX_W/LAT_W widths, FU_* indices, busy_t counter type,
//           lat_to_busy (latency -> remaining busy cycles), ptr_inc (wrapping pointer).
package issue_pkg;

    localparam int unsigned RS_ENTRIES = 8;
    localparam int unsigned NUM_FU     = 3;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned LAT_W      = 3;

    localparam int unsigned FU_ALU0 = 0;
    localparam int unsigned FU_ALU1 = 1;
    localparam int unsigned FU_MUL  = 2;

    typedef logic [LAT_W-1:0] busy_t;

    // Cycles the FU stays occupied after the issue cycle; latency 0 behaves as 1.
    function automatic busy_t lat_to_busy(input logic [LAT_W-1:0] lat);
        return (lat == '0) ? '0 : busy_t'(lat - 1'b1);
    endfunction

    // Round-robin pointer successor, wrapping from RS_ENTRIES-1 to 0.
    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (32'(p) == RS_ENTRIES - 1) ? '0 : IDX_W'(p + 1'b1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Purpose: combinational round-robin picker; finds the first set request at or after
//          start_i (wrapping modulo N) via rotate, priority-encode, unrotate.
// Ports:   req_i   - request vector
//          start_i - index where the search begins
//          found_o - any request set
//          idx_o   - chosen index (0 when nothing found)
module rr_picker #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    localparam int unsigned W1 = W + 1;
    localparam logic [W:0]  NW = W1'(N);

    logic [N-1:0] rot;
    logic [W:0]   src;
    logic [W-1:0] pos;
    logic [W:0]   sum;

    // Rotate so that start_i lands at bit 0.
    always_comb begin
        rot = '0;
        src = '0;
        for (int i = 0; i < int'(N); i++) begin
            src = {1'b0, start_i} + W1'(i);
            if (src >= NW) begin
                src = src - NW;
            end
            rot[i] = req_i[src[W-1:0]];
        end
    end

    // Lowest set bit of the rotated vector, mapped back to an absolute index.
    always_comb begin
        found_o = 1'b0;
        pos     = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (rot[i] && !found_o) begin
                found_o = 1'b1;
                pos     = W'(i);
            end
        end
        sum = {1'b0, pos} + {1'b0, start_i};
        if (sum >= NW) begin
            sum = sum - NW;
        end
        idx_o = found_o ? sum[W-1:0] : '0;
    end

endmodule

// File: rtl/issue_scheduler.sv
// Purpose: picks up to one ready RS entry per functional unit each cycle with per-FU
//          round-robin fairness, and tracks multi-cycle FU occupancy.
// Ports:   clk, rst (async, active-low)
//          req_valid/req_fu_mask/req_lat - per-entry request, FU eligibility, latency
//          fu_ready, flush               - FU acceptance and pipeline flush
//          grant_valid/grant_idx         - zero-latency issue per FU
//          entry_granted                 - union of this cycle's granted entries
//          fu_busy                       - FU occupied by a multi-cycle op
// Option:  ISSUE_PERF_CNT_EN adds perf_issue_cnt / perf_stall_cnt (saturating,
//          cleared by reset or flush).
module issue_scheduler
    import issue_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RS_ENTRIES-1:0]        req_valid,
    input  logic [RS_ENTRIES*NUM_FU-1:0] req_fu_mask,
    input  logic [RS_ENTRIES*LAT_W-1:0]  req_lat,
    input  logic [NUM_FU-1:0]            fu_ready,
    input  logic                         flush,
    output logic [NUM_FU-1:0]            grant_valid,
    output logic [NUM_FU*IDX_W-1:0]      grant_idx,
    output logic [RS_ENTRIES-1:0]        entry_granted,
    output logic [NUM_FU-1:0]            fu_busy
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_issue_cnt,
    output logic [31:0]                  perf_stall_cnt
`endif
);

    logic [IDX_W-1:0] rr_ptr_q [NUM_FU];
    logic [IDX_W-1:0] rr_ptr_d [NUM_FU];
    busy_t            busy_q   [NUM_FU];
    busy_t            busy_d   [NUM_FU];
    logic [LAT_W-1:0] lat_arr  [RS_ENTRIES];

    // Unpack per-entry latency fields.
    always_comb begin
        for (int e = 0; e < int'(RS_ENTRIES); e++) begin
            lat_arr[e] = req_lat[e*LAT_W +: LAT_W];
        end
    end

    // Per-FU arbitration; entries granted to lower-index FUs are masked off downstream.
    for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
        logic [RS_ENTRIES-1:0] fu_mask;
        logic [RS_ENTRIES-1:0] excl_in;
        logic [RS_ENTRIES-1:0] excl_out;
        logic [RS_ENTRIES-1:0] cand;
        logic                  pick_found;
        logic [IDX_W-1:0]      pick_idx;
        logic                  fu_free;
        logic                  gv;

        if (f == 0) begin : g_head
            assign excl_in = '0;
        end else begin : g_chain
            assign excl_in = g_fu[f-1].excl_out;
        end

        always_comb begin
            fu_mask = '0;
            for (int e = 0; e < int'(RS_ENTRIES); e++) begin
                fu_mask[e] = req_fu_mask[e*NUM_FU + f];
            end
        end

        assign cand = req_valid & fu_mask & ~excl_in;

        rr_picker #(
            .N (RS_ENTRIES),
            .W (IDX_W)
        ) u_pick (
            .req_i   (cand),
            .start_i (rr_ptr_q[f]),
            .found_o (pick_found),
            .idx_o   (pick_idx)
        );

        // rst gating keeps grants at zero while reset is held, whatever the inputs do.
        assign fu_free  = rst & ~flush & fu_ready[f] & (busy_q[f] == '0);
        assign gv       = fu_free & pick_found;
        assign excl_out = gv ? (excl_in | (RS_ENTRIES'(1) << pick_idx)) : excl_in;

        assign grant_valid[f]              = gv;
        assign grant_idx[f*IDX_W +: IDX_W] = gv ? pick_idx : '0;
        assign fu_busy[f]                  = (busy_q[f] != '0);
    end

    assign entry_granted = g_fu[NUM_FU-1].excl_out;

    // Pointer advance and busy countdown; flush clears occupancy but keeps fairness state.
    always_comb begin
        logic [IDX_W-1:0] gi;
        gi = '0;
        for (int f = 0; f < int'(NUM_FU); f++) begin
            rr_ptr_d[f] = rr_ptr_q[f];
            busy_d[f]   = busy_q[f];
            gi          = grant_idx[f*IDX_W +: IDX_W];
            if (flush) begin
                busy_d[f] = '0;
            end else if (grant_valid[f]) begin
                rr_ptr_d[f] = ptr_inc(gi);
                busy_d[f]   = lat_to_busy(lat_arr[gi]);
            end else if (busy_q[f] != '0) begin
                busy_d[f] = busy_q[f] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int f = 0; f < int'(NUM_FU); f++) begin
                rr_ptr_q[f] <= '0;
                busy_q[f]   <= '0;
            end
        end else begin
            for (int f = 0; f < int'(NUM_FU); f++) begin
                rr_ptr_q[f] <= rr_ptr_d[f];
                busy_q[f]   <= busy_d[f];
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0]  issue_cnt_q;
    logic [31:0]  issue_cnt_d;
    logic [31:0]  stall_cnt_q;
    logic [31:0]  stall_cnt_d;
    logic [32:0]  issue_sum;
    int unsigned  n_grants;

    // Saturating counters; a stall is pending work with nothing issued.
    always_comb begin
        n_grants = 0;
        for (int f = 0; f < int'(NUM_FU); f++) begin
            n_grants = n_grants + 32'(grant_valid[f]);
        end
        issue_sum   = {1'b0, issue_cnt_q} + 33'(n_grants);
        issue_cnt_d = issue_sum[32] ? '1 : issue_sum[31:0];
        stall_cnt_d = stall_cnt_q;
        if ((|req_valid) && (grant_valid == '0) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush) begin
            issue_cnt_d = '0;
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_issue_cnt = issue_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Purpose: directed self-checking bench for issue_scheduler. Each step drives inputs
//          after the falling edge, pushes the expected outputs to a scoreboard queue,
//          and pops/compares them before the next rising edge.
module tb_issue_scheduler;

    logic        clk;
    logic        rst;
    logic [7:0]  req_valid;
    logic [23:0] req_fu_mask;
    logic [23:0] req_lat;
    logic [2:0]  fu_ready;
    logic        flush;
    logic [2:0]  grant_valid;
    logic [8:0]  grant_idx;
    logic [7:0]  entry_granted;
    logic [2:0]  fu_busy;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    issue_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_fu_mask   (req_fu_mask),
        .req_lat       (req_lat),
        .fu_ready      (fu_ready),
        .flush         (flush),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .entry_granted (entry_granted),
        .fu_busy       (fu_busy)
`ifdef ISSUE_PERF_CNT_EN
        ,
        .perf_issue_cnt(perf_issue_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct packed {
        logic [2:0] gv;
        logic [8:0] gidx;
        logic [7:0] eg;
        logic [2:0] busy;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] gi3(input int i2, input int i1, input int i0);
        return {3'(i2), 3'(i1), 3'(i0)};
    endfunction

    task automatic clear_reqs();
        req_valid   = '0;
        req_fu_mask = '0;
        req_lat     = '0;
    endtask

    task automatic set_req(input int e, input logic [2:0] mask, input logic [2:0] lat);
        req_valid[e]           = 1'b1;
        req_fu_mask[e*3 +: 3]  = mask;
        req_lat[e*3 +: 3]      = lat;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] gv, input logic [8:0] gidx,
                              input logic [7:0] eg, input logic [2:0] busy);
        exp_t e;
        e.gv = gv; e.gidx = gidx; e.eg = eg; e.busy = busy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (grant_valid === e.gv) else begin
            failures++;
            $error("FAIL %s grant_valid: got %b want %b", t, grant_valid, e.gv);
        end
        checks++;
        assert (grant_idx === e.gidx) else begin
            failures++;
            $error("FAIL %s grant_idx: got %h want %h", t, grant_idx, e.gidx);
        end
        checks++;
        assert (entry_granted === e.eg) else begin
            failures++;
            $error("FAIL %s entry_granted: got %b want %b", t, entry_granted, e.eg);
        end
        checks++;
        assert (fu_busy === e.busy) else begin
            failures++;
            $error("FAIL %s fu_busy: got %b want %b", t, fu_busy, e.busy);
        end
    endtask

    initial begin
        // Reset held with active-looking inputs: everything must read zero.
        rst         = 1'b0;
        flush       = 1'b0;
        fu_ready    = 3'b111;
        req_valid   = 8'hFF;
        req_fu_mask = '1;
        req_lat     = '0;
        expect_out("in_reset", 3'b000, 9'd0, 8'h00, 3'b000);
        #2 check_out();

        @(negedge clk);
        rst = 1'b1;
        clear_reqs();
        expect_out("idle", 3'b000, 9'd0, 8'h00, 3'b000);
        #2 check_out();

        // Two entries on all FUs: FU0 -> 2, FU1 -> 5, FU2 idle.
        @(negedge clk);
        clear_reqs();
        set_req(2, 3'b111, 3'd1);
        set_req(5, 3'b111, 3'd1);
        expect_out("dual", 3'b011, gi3(0, 5, 2), 8'b0010_0100, 3'b000);
        #2 check_out();

        // Round robin on FU0 with entries 0,1 held (rr0 starts at 3 -> wraps to 0).
        @(negedge clk);
        clear_reqs();
        set_req(0, 3'b001, 3'd1);
        set_req(1, 3'b001, 3'd1);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            expect_out($sformatf("rr%0d", k), 3'b001, gi3(0, 0, k % 2),
                       8'(1 << (k % 2)), 3'b000);
            #2 check_out();
        end

        // Multi-cycle op: entry 3 on FU2 with latency 4.
        @(negedge clk);
        clear_reqs();
        set_req(3, 3'b100, 3'd4);
        expect_out("mc_issue", 3'b100, gi3(3, 0, 0), 8'b0000_1000, 3'b000);
        #2 check_out();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            clear_reqs();
            set_req(4, 3'b100, 3'd0);
            expect_out($sformatf("mc_busy%0d", k), 3'b000, 9'd0, 8'h00, 3'b100);
            #2 check_out();
        end
        @(negedge clk);
        expect_out("mc_next", 3'b100, gi3(4, 0, 0), 8'b0001_0000, 3'b000);
        #2 check_out();
        // Latency 0 behaves as 1: no busy afterwards.
        @(negedge clk);
        clear_reqs();
        expect_out("lat0", 3'b000, 9'd0, 8'h00, 3'b000);
        #2 check_out();

        // Flush one cycle into a latency-4 op on FU2 (rr2 = 5 -> picks 6).
        @(negedge clk);
        set_req(6, 3'b100, 3'd4);
        expect_out("fl_issue", 3'b100, gi3(6, 0, 0), 8'b0100_0000, 3'b000);
        #2 check_out();
        @(negedge clk);
        clear_reqs();
        set_req(7, 3'b111, 3'd1);
        flush = 1'b1;
        expect_out("fl_cycle", 3'b000, 9'd0, 8'h00, 3'b100);
        #2 check_out();
        @(negedge clk);
        flush = 1'b0;
        clear_reqs();
        set_req(7, 3'b100, 3'd1);
        expect_out("fl_after", 3'b100, gi3(7, 0, 0), 8'b1000_0000, 3'b000);
        #2 check_out();
        // rr2 wrapped from 7 to 0: entry 0 wins over entry 7.
        @(negedge clk);
        clear_reqs();
        set_req(0, 3'b100, 3'd1);
        set_req(7, 3'b100, 3'd1);
        expect_out("wrap", 3'b100, gi3(0, 0, 0), 8'b0000_0001, 3'b000);
        #2 check_out();

        // FU0 not ready stalls; all-zero mask entry 5 is never granted.
        @(negedge clk);
        clear_reqs();
        set_req(1, 3'b001, 3'd1);
        set_req(5, 3'b000, 3'd1);
        fu_ready = 3'b110;
        expect_out("stall", 3'b000, 9'd0, 8'h00, 3'b000);
        #2 check_out();
        @(negedge clk);
        fu_ready = 3'b111;
        expect_out("unstall", 3'b001, gi3(0, 0, 1), 8'b0000_0010, 3'b000);
        #2 check_out();

        // Async reset in the middle of a latency-7 op.
        @(negedge clk);
        clear_reqs();
        set_req(2, 3'b100, 3'd7);
        expect_out("rs_issue", 3'b100, gi3(2, 0, 0), 8'b0000_0100, 3'b000);
        #2 check_out();
        @(negedge clk);
        clear_reqs();
        expect_out("rs_busy", 3'b000, 9'd0, 8'h00, 3'b100);
        #2 check_out();
        @(negedge clk);
        set_req(0, 3'b001, 3'd1);
        set_req(3, 3'b001, 3'd1);
        set_req(1, 3'b010, 3'd1);
        set_req(6, 3'b010, 3'd1);
        set_req(2, 3'b100, 3'd1);
        set_req(7, 3'b100, 3'd1);
        #1 rst = 1'b0;
        expect_out("rs_async", 3'b000, 9'd0, 8'h00, 3'b000);
        #1 check_out();
        @(negedge clk);
        rst = 1'b1;
        // Pointers back at 0 pick the lowest candidate on every FU.
        expect_out("rs_release", 3'b111, gi3(2, 1, 0), 8'b0000_0111, 3'b000);
        #2 check_out();

        checks++;
        assert (exp_q.size() === 0) else begin
            failures++;
            $error("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
